line_follower_ctrl: RTL and testbench

Decision and timebase stage directly upstream of the servo PWM generators (one per wheel). It generates the 20 ms servo frame counter and a per-frame restart pulse. It also samples the three line sensors once per frame and runs a steering FSM. Per-wheel direction/brake commands are held constant for a whole frame, so each PWM stage sees stable inputs for the full frame.

---
 rtl/line_follower_pkg.sv | 44 ++++
 rtl/line_follower_ctrl_frame_timer.sv | 35 +++
 rtl/line_follower_ctrl.sv | 159 +++++++++++++++
 tb/tb_line_follower_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_follower_pkg.sv
// Shared types and defaults for the line follower controller.
//   state_t     : steering FSM states (encoding is visible on state_dbg)
//   wheel_cmd_t : per-wheel command
//   side_t      : side on which the line was last seen
package line_follower_pkg;

  typedef enum logic [2:0] {
    FORWARD      = 3'd0,
    GENTLE_LEFT  = 3'd1,
    SHARP_LEFT   = 3'd2,
    GENTLE_RIGHT = 3'd3,
    SHARP_RIGHT  = 3'd4,
    SEARCH       = 3'd5,
    STOP         = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    FWD  = 2'd0,
    REV  = 2'd1,
    HOLD = 2'd2
  } wheel_cmd_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_t;

  localparam int unsigned DEFAULT_PERIOD        = 2_000_000;
  localparam int unsigned DEFAULT_SEARCH_FRAMES = 100;
  localparam int unsigned DEFAULT_CW            = 21;

  // Returns {dir, brake}. fwd_dir is the dir level that drives this wheel
  // forward; the two motors are mounted mirrored so it differs per side.
  function automatic logic [1:0] wheel_bits(wheel_cmd_t cmd, logic fwd_dir);
    logic [1:0] bits;
    case (cmd)
      FWD:     bits = {fwd_dir, 1'b0};
      REV:     bits = {~fwd_dir, 1'b0};
      default: bits = 2'b01;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/line_follower_ctrl_frame_timer.sv
// Servo frame timebase.
//   clk, reset  : system clock, async active-low reset
//   count_out   : free-running frame counter 0..PERIOD-1
//   frame_tick  : high while count_out == PERIOD-1 (combinational)
//   motor_reset : registered, high during the count_out == 0 cycle and in reset
module frame_timer
  import line_follower_pkg::*;
#(
  parameter int unsigned PERIOD = DEFAULT_PERIOD,
  parameter int unsigned CW     = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] count_out,
  output logic          frame_tick,
  output logic          motor_reset
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  assign frame_tick = (count_out == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_out   <= '0;
      motor_reset <= 1'b1;
    end else begin
      // The cycle after the last count is count 0, so restart goes high with it.
      motor_reset <= frame_tick;
      if (frame_tick) count_out <= '0;
      else            count_out <= count_out + CW'(1);
    end
  end

endmodule

// File: rtl/line_follower_ctrl.sv
// Line follower decision stage: frame timebase, sensor sync/filter and
// steering FSM driving the per-wheel direction/brake commands.
//   clk, reset             : system clock, async active-low reset
//   sensor_l/m/r           : line sensors (1 = line), asynchronous to clk
//   count_out, motor_reset : timebase to the PWM stages
//   frame_tick             : one-cycle pulse on the last count of a frame
//   dir_l/brake_l/dir_r/brake_r : wheel commands, constant for a whole frame
//   state_dbg              : current state encoding
//
// state        | meaning
// FORWARD      | line centred, both wheels forward
// GENTLE_LEFT  | line slightly left, left wheel held
// SHARP_LEFT   | line far left, left wheel reversed
// GENTLE_RIGHT | line slightly right, right wheel held
// SHARP_RIGHT  | line far right, right wheel reversed
// SEARCH       | line lost, pivot toward last seen side
// STOP         | line lost too long, both wheels held until reset
module line_follower_ctrl
  import line_follower_pkg::*;
#(
  parameter int unsigned PERIOD        = DEFAULT_PERIOD,
  parameter int unsigned SEARCH_FRAMES = DEFAULT_SEARCH_FRAMES,
  parameter int unsigned CW            = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sensor_l,
  input  logic          sensor_m,
  input  logic          sensor_r,
  output logic [CW-1:0] count_out,
  output logic          motor_reset,
  output logic          frame_tick,
  output logic          dir_l,
  output logic          brake_l,
  output logic          dir_r,
  output logic          brake_r,
  output logic [2:0]    state_dbg
);

  localparam int unsigned    SCW         = $clog2(SEARCH_FRAMES + 1);
  localparam logic [SCW-1:0] SEARCH_LAST = SCW'(SEARCH_FRAMES - 1);

  frame_timer #(
    .PERIOD (PERIOD),
    .CW     (CW)
  ) u_frame_timer (
    .clk         (clk),
    .reset       (reset),
    .count_out   (count_out),
    .frame_tick  (frame_tick),
    .motor_reset (motor_reset)
  );

  logic [2:0]     sync_a, pattern, prev_p;
  state_t         state, state_n;
  side_t          last_side, last_side_n;
  logic [SCW-1:0] search_cnt, search_cnt_n;
  logic           accepted;
  wheel_cmd_t     cmd_l, cmd_r;
  logic [1:0]     bits_l, bits_r;

  function automatic state_t steer(logic [2:0] p, state_t cur);
    state_t nxt;
    case (p)
      3'b010, 3'b111: nxt = FORWARD;
      3'b110:         nxt = GENTLE_LEFT;
      3'b100:         nxt = SHARP_LEFT;
      3'b011:         nxt = GENTLE_RIGHT;
      3'b001:         nxt = SHARP_RIGHT;
      3'b000:         nxt = SEARCH;
      default:        nxt = cur;
    endcase
    return nxt;
  endfunction

  always_comb begin
    state_n      = state;
    search_cnt_n = search_cnt;
    last_side_n  = last_side;
    accepted     = frame_tick && (pattern == prev_p);

    if (frame_tick && state != STOP) begin
      if (state == SEARCH) begin
        // 101 holds state like anywhere else, so it only counts as lost time.
        if (accepted && pattern != 3'b000 && pattern != 3'b101) begin
          state_n      = steer(pattern, state);
          search_cnt_n = '0;
        end else if (search_cnt == SEARCH_LAST) begin
          if (accepted) state_n = STOP;
        end else begin
          search_cnt_n = search_cnt + SCW'(1);
        end
      end else if (accepted) begin
        state_n = steer(pattern, state);
      end
    end

    case (state_n)
      GENTLE_LEFT, SHARP_LEFT:   last_side_n = LEFT;
      GENTLE_RIGHT, SHARP_RIGHT: last_side_n = RIGHT;
      default:                   last_side_n = last_side;
    endcase

    cmd_l = FWD;
    cmd_r = FWD;
    case (state_n)
      GENTLE_LEFT:  cmd_l = HOLD;
      SHARP_LEFT:   cmd_l = REV;
      GENTLE_RIGHT: cmd_r = HOLD;
      SHARP_RIGHT:  cmd_r = REV;
      SEARCH: begin
        if (last_side_n == LEFT) cmd_l = REV;
        else                     cmd_r = REV;
      end
      STOP: begin
        cmd_l = HOLD;
        cmd_r = HOLD;
      end
      default: begin
        cmd_l = FWD;
        cmd_r = FWD;
      end
    endcase

    bits_l = wheel_bits(cmd_l, 1'b1);
    bits_r = wheel_bits(cmd_r, 1'b0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a     <= '0;
      pattern    <= '0;
      prev_p     <= '0;
      state      <= FORWARD;
      last_side  <= LEFT;
      search_cnt <= '0;
      dir_l      <= 1'b0;
      brake_l    <= 1'b1;
      dir_r      <= 1'b0;
      brake_r    <= 1'b1;
    end else begin
      sync_a  <= {sensor_l, sensor_m, sensor_r};
      pattern <= sync_a;
      // Everything below moves only on the wrap edge so the PWM stages see
      // one command for the whole frame.
      if (frame_tick) begin
        prev_p     <= pattern;
        state      <= state_n;
        last_side  <= last_side_n;
        search_cnt <= search_cnt_n;
        {dir_l, brake_l} <= bits_l;
        {dir_r, brake_r} <= bits_r;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_line_follower_ctrl.sv
module tb_line_follower_ctrl;

  localparam int PER = 1000;
  localparam logic [2:0] S_FWD = 3'd0, S_GL = 3'd1, S_GR = 3'd3, S_SR = 3'd4,
                         S_SEARCH = 3'd5, S_STOP = 3'd6;
  // {dir_l, brake_l, dir_r, brake_r}
  localparam logic [3:0] C_FWD = 4'b1000, C_GL = 4'b0100, C_GR = 4'b1001,
                         C_SR = 4'b1010, C_PIV_L = 4'b0000, C_PIV_R = 4'b1010,
                         C_HOLD = 4'b0101;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_l, sensor_m, sensor_r;
  logic [9:0] count_out;
  logic       motor_reset, frame_tick;
  logic       dir_l, brake_l, dir_r, brake_r;
  logic [2:0] state_dbg;
  logic [3:0] cmd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign cmd = {dir_l, brake_l, dir_r, brake_r};

  line_follower_ctrl #(.PERIOD(PER), .SEARCH_FRAMES(4), .CW(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_l    (sensor_l),
    .sensor_m    (sensor_m),
    .sensor_r    (sensor_r),
    .count_out   (count_out),
    .motor_reset (motor_reset),
    .frame_tick  (frame_tick),
    .dir_l       (dir_l),
    .brake_l     (brake_l),
    .dir_r       (dir_r),
    .brake_r     (brake_r),
    .state_dbg   (state_dbg)
  );

  task automatic set_p(input logic [2:0] p);
    {sensor_l, sensor_m, sensor_r} = p;
  endtask

  task automatic wait_count(input int target);
    int k;
    k = 0;
    while (count_out != 10'(target) && k < PER + 100) begin
      @(negedge clk);
      k++;
    end
    if (count_out != 10'(target)) begin
      n_checks++; n_fail++;
      $display("FAIL wait_count: count_out=%0d never reached %0d", count_out, target);
    end
  endtask

  // Returns just after the wrap edge (count_out == 0).
  task automatic next_frame();
    wait_count(PER - 1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_p(3'b000);
    #2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (motor_reset !== 1'b1) begin
        n_fail++; $display("FAIL reset_motor_reset: got %b want 1", motor_reset);
      end
    end
    n_checks++;
    if (count_out !== 10'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_out); end
    n_checks++;
    if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
    n_checks++;
    if (state_dbg !== S_FWD) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_FWD); end
    n_checks++;
    if (cmd !== C_HOLD) begin n_fail++; $display("FAIL reset_cmd: got %b want %b", cmd, C_HOLD); end
  endtask

  task automatic test_timer();
    int exp_cnt;
    set_p(3'b010);
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < PER + 100; i++) begin
      n_checks++;
      if (count_out !== 10'(exp_cnt)) begin
        n_fail++; $display("FAIL timer_count: got %0d want %0d", count_out, exp_cnt);
      end
      n_checks++;
      if (frame_tick !== (exp_cnt == PER - 1)) begin
        n_fail++; $display("FAIL timer_tick at %0d: got %b want %b", exp_cnt, frame_tick, exp_cnt == PER - 1);
      end
      n_checks++;
      if (motor_reset !== (exp_cnt == 0)) begin
        n_fail++; $display("FAIL timer_motor_reset at %0d: got %b want %b", exp_cnt, motor_reset, exp_cnt == 0);
      end
      exp_cnt = (exp_cnt + 1) % PER;
      @(negedge clk);
    end
    // First tick saw 010 once (not yet accepted) but refreshes the outputs.
    n_checks++;
    if (state_dbg !== S_FWD) begin n_fail++; $display("FAIL timer_state: got %0d want %0d", state_dbg, S_FWD); end
    n_checks++;
    if (cmd !== C_FWD) begin n_fail++; $display("FAIL timer_cmd: got %b want %b", cmd, C_FWD); end
  endtask

  task automatic test_steering();
    next_frame();
    set_p(3'b110);
    next_frame();
    n_checks++;
    if (state_dbg !== S_FWD) begin n_fail++; $display("FAIL steer_first_tick: got %0d want %0d", state_dbg, S_FWD); end
    wait_count(PER - 1);
    n_checks++;
    if (cmd !== C_FWD) begin n_fail++; $display("FAIL steer_before_wrap: got %b want %b", cmd, C_FWD); end
    @(negedge clk);
    n_checks++;
    if (count_out !== 10'd0 || state_dbg !== S_GL) begin
      n_fail++; $display("FAIL steer_second_tick: count %0d state %0d want count 0 state %0d", count_out, state_dbg, S_GL);
    end
    n_checks++;
    if (cmd !== C_GL) begin n_fail++; $display("FAIL steer_gl_cmd: got %b want %b", cmd, C_GL); end
    next_frame();
    n_checks++;
    if (state_dbg !== S_GL) begin n_fail++; $display("FAIL steer_third_frame: got %0d want %0d", state_dbg, S_GL); end
  endtask

  task automatic test_filter();
    set_p(3'b010);
    next_frame();
    next_frame();
    n_checks++;
    if (state_dbg !== S_FWD) begin n_fail++; $display("FAIL filter_back_fwd: got %0d want %0d", state_dbg, S_FWD); end
    set_p(3'b100);
    next_frame();
    set_p(3'b010);
    next_frame();
    n_checks++;
    if (state_dbg !== S_FWD) begin n_fail++; $display("FAIL filter_one_frame: got %0d want %0d", state_dbg, S_FWD); end
    next_frame();
    n_checks++;
    if (state_dbg !== S_FWD || cmd !== C_FWD) begin
      n_fail++; $display("FAIL filter_after: state %0d cmd %b want %0d %b", state_dbg, cmd, S_FWD, C_FWD);
    end
    wait_count(500);
    sensor_r = 1'b1;
    @(negedge clk);
    sensor_r = 1'b0;
    next_frame();
    n_checks++;
    if (state_dbg !== S_FWD || cmd !== C_FWD) begin
      n_fail++; $display("FAIL filter_glitch: state %0d cmd %b want %0d %b", state_dbg, cmd, S_FWD, C_FWD);
    end
  endtask

  task automatic test_search();
    set_p(3'b001);
    next_frame();
    next_frame();
    n_checks++;
    if (state_dbg !== S_SR || cmd !== C_SR) begin
      n_fail++; $display("FAIL search_sharp_right: state %0d cmd %b want %0d %b", state_dbg, cmd, S_SR, C_SR);
    end
    set_p(3'b000);
    next_frame();
    next_frame();
    n_checks++;
    if (state_dbg !== S_SEARCH || cmd !== C_PIV_R) begin
      n_fail++; $display("FAIL search_enter: state %0d cmd %b want %0d %b", state_dbg, cmd, S_SEARCH, C_PIV_R);
    end
    for (int i = 0; i < 3; i++) next_frame();
    n_checks++;
    if (state_dbg !== S_SEARCH) begin n_fail++; $display("FAIL search_before_stop: got %0d want %0d", state_dbg, S_SEARCH); end
    next_frame();
    n_checks++;
    if (state_dbg !== S_STOP || cmd !== C_HOLD) begin
      n_fail++; $display("FAIL search_stop: state %0d cmd %b want %0d %b", state_dbg, cmd, S_STOP, C_HOLD);
    end
    set_p(3'b010);
    next_frame();
    next_frame();
    n_checks++;
    if (state_dbg !== S_STOP || cmd !== C_HOLD) begin
      n_fail++; $display("FAIL stop_sticky: state %0d cmd %b want %0d %b", state_dbg, cmd, S_STOP, C_HOLD);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    wait_count(500);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (count_out !== 10'd0 || motor_reset !== 1'b1) begin
      n_fail++; $display("FAIL async_timer: count %0d motor_reset %b want 0 1", count_out, motor_reset);
    end
    n_checks++;
    if (state_dbg !== S_FWD || cmd !== C_HOLD) begin
      n_fail++; $display("FAIL async_fsm: state %0d cmd %b want %0d %b", state_dbg, cmd, S_FWD, C_HOLD);
    end
    set_p(3'b101);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (frame_tick !== 1'b1 && cyc < PER + 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != PER - 1) begin n_fail++; $display("FAIL async_first_tick: after %0d cycles want %0d", cyc, PER - 1); end
    @(negedge clk);
    next_frame();
    n_checks++;
    if (state_dbg !== S_FWD || cmd !== C_FWD) begin
      n_fail++; $display("FAIL p101_hold: state %0d cmd %b want %0d %b", state_dbg, cmd, S_FWD, C_FWD);
    end
  endtask

  task automatic test_reacquire();
    set_p(3'b000);
    next_frame();
    next_frame();
    n_checks++;
    if (state_dbg !== S_SEARCH || cmd !== C_PIV_L) begin
      n_fail++; $display("FAIL reacq_search_left: state %0d cmd %b want %0d %b", state_dbg, cmd, S_SEARCH, C_PIV_L);
    end
    next_frame();
    set_p(3'b011);
    next_frame();
    n_checks++;
    if (state_dbg !== S_SEARCH) begin n_fail++; $display("FAIL reacq_pending: got %0d want %0d", state_dbg, S_SEARCH); end
    next_frame();
    n_checks++;
    if (state_dbg !== S_GR || cmd !== C_GR) begin
      n_fail++; $display("FAIL reacq_gentle_right: state %0d cmd %b want %0d %b", state_dbg, cmd, S_GR, C_GR);
    end
    set_p(3'b000);
    next_frame();
    next_frame();
    n_checks++;
    if (state_dbg !== S_SEARCH || cmd !== C_PIV_R) begin
      n_fail++; $display("FAIL reacq_search_right: state %0d cmd %b want %0d %b", state_dbg, cmd, S_SEARCH, C_PIV_R);
    end
    for (int i = 0; i < 3; i++) begin
      next_frame();
      n_checks++;
      if (state_dbg !== S_SEARCH) begin
        n_fail++; $display("FAIL reacq_full_count frame %0d: got %0d want %0d", i + 1, state_dbg, S_SEARCH);
      end
    end
    next_frame();
    n_checks++;
    if (state_dbg !== S_STOP) begin n_fail++; $display("FAIL reacq_stop: got %0d want %0d", state_dbg, S_STOP); end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_steering();
    test_filter();
    test_search();
    test_async_reset();
    test_reacquire();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
